// File: rtl/osc_pkg.sv
// osc_pkg: constants and types shared between the trigger and the capture reader
package osc_pkg;
    localparam int SAMPLES  = 512;
    localparam int DATA_W   = 12;
    localparam int X_OFFSET = 144;
    localparam int Y_BOTTOM = 599;
    localparam int Y_SHIFT  = 3;
    typedef enum logic [1:0] {ARM, STREAM, DONE} reader_state_t;
endpackage

// File: rtl/sample_minmax.sv
// sample_minmax: per-frame running min/max with results latched at end of frame
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : restart running min (all-ones) and max (zero)
//   acc, data  : fold data into the running min/max
//   latch      : publish vmin/vmax/vpp; includes a sample accumulated in the same cycle
//   vmin, vmax, vpp : last published frame results
module sample_minmax #(
    parameter int DATA_W = osc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc,
    input  logic              latch,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vpp
);
    logic [DATA_W-1:0] run_min, run_max, nxt_min, nxt_max;

    always_comb begin
        nxt_min = (acc && data < run_min) ? data : run_min;
        nxt_max = (acc && data > run_max) ? data : run_max;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_min <= '0;
            run_max <= '0;
            vmin    <= '0;
            vmax    <= '0;
            vpp     <= '0;
        end else begin
            run_min <= clear ? '1 : nxt_min;
            run_max <= clear ? '0 : nxt_max;
            if (latch) begin
                vmin <= nxt_min;
                vmax <= nxt_max;
                // nxt_max >= nxt_min once a frame has at least one sample
                vpp  <= nxt_max - nxt_min;
            end
        end
    end
endmodule

// File: rtl/capture_reader.sv
// capture_reader: streams a captured frame with screen coordinates and measures min/max
//   clk, rst        : clock, asynchronous active-low reset
//   capture_buffer  : frame samples from the trigger
//   read            : capture-complete level; a rising edge in ARM starts a frame
//   ready           : high lets the trigger capture, low freezes the buffer
//   sample_valid/ready, sample_raw/x/y/last : output sample stream
//   meas_valid, vmin, vmax, vpp : frame measurement results
module capture_reader #(
    parameter int SAMPLES  = osc_pkg::SAMPLES,
    parameter int DATA_W   = osc_pkg::DATA_W,
    parameter int X_OFFSET = osc_pkg::X_OFFSET,
    parameter int Y_BOTTOM = osc_pkg::Y_BOTTOM,
    parameter int Y_SHIFT  = osc_pkg::Y_SHIFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] capture_buffer [SAMPLES],
    input  logic              read,
    output logic              ready,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_raw,
    output logic [10:0]       sample_x,
    output logic [9:0]        sample_y,
    output logic              sample_last,
    output logic              meas_valid,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vpp
);
    import osc_pkg::*;

    localparam int IDX_W = $clog2(SAMPLES);

    reader_state_t     state, state_nxt;
    logic              read_q, rise, hs, start, step, fin, load;
    logic [IDX_W-1:0]  index, load_idx;

    assign rise     = read && !read_q;
    assign hs       = sample_valid && sample_ready;
    assign load     = start || (step && !fin);
    assign load_idx = start ? '0 : index + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ARM;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state)
            ARM: if (rise) begin
                start     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: if (hs) begin
                step = 1'b1;
                if (sample_last) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready        <= 1'b1;
            read_q       <= 1'b1;
            index        <= '0;
            sample_valid <= 1'b0;
            sample_raw   <= '0;
            sample_x     <= '0;
            sample_y     <= '0;
            sample_last  <= 1'b0;
            meas_valid   <= 1'b0;
        end else begin
            // read_q tracks read in every state so a held level never looks like a new edge
            read_q     <= read;
            meas_valid <= fin;
            if (start)              ready <= 1'b0;
            else if (state == DONE) ready <= 1'b1;
            if (load) begin
                index        <= load_idx;
                sample_valid <= 1'b1;
                sample_raw   <= capture_buffer[load_idx];
                sample_x     <= 11'(X_OFFSET) + 11'(load_idx);
                sample_y     <= 10'(Y_BOTTOM) - 10'(capture_buffer[load_idx] >> Y_SHIFT);
                sample_last  <= (load_idx == IDX_W'(SAMPLES - 1));
            end else if (fin) begin
                sample_valid <= 1'b0;
                sample_last  <= 1'b0;
            end
        end
    end

    // the final handshake both folds the last sample and publishes, so results show during DONE
    sample_minmax #(.DATA_W(DATA_W)) u_minmax (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .acc   (step),
        .latch (fin),
        .data  (sample_raw),
        .vmin  (vmin),
        .vmax  (vmax),
        .vpp   (vpp)
    );
endmodule

// File: tb/tb_capture_reader.sv
// tb_capture_reader: directed and randomized checks of capture_reader against a frame model
module tb_capture_reader;
    import osc_pkg::*;

    logic              clk = 1'b0, rst = 1'b1, read = 1'b1, sample_ready = 1'b0;
    logic [DATA_W-1:0] cap [SAMPLES];
    logic              ready, sample_valid, sample_last, meas_valid;
    logic [DATA_W-1:0] sample_raw, vmin, vmax, vpp;
    logic [10:0]       sample_x;
    logic [9:0]        sample_y;
    int                errors = 0, checks = 0;
    int                model [SAMPLES];

    always #5 clk = ~clk;

    capture_reader dut (
        .clk(clk), .rst(rst), .capture_buffer(cap), .read(read), .ready(ready),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_raw(sample_raw),
        .sample_x(sample_x), .sample_y(sample_y), .sample_last(sample_last),
        .meas_valid(meas_valid), .vmin(vmin), .vmax(vmax), .vpp(vpp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: ramp i*8, mode 1: random, mode 2: constant 2048
    task automatic load(input int mode);
        for (int i = 0; i < SAMPLES; i++) begin
            model[i] = (mode == 0) ? i * 8 : (mode == 1) ? int'($urandom_range(4095)) : 2048;
            cap[i]   = DATA_W'(model[i]);
        end
    endtask

    // starts a frame with a low->high read pulse and follows it to completion;
    // abort >= 0 returns while index abort is being presented
    task automatic run_frame(input int pct, input bit toggle, input int abort);
        int k, cyc, mn, mx;
        k = 0; cyc = 0; mn = 4095; mx = 0;
        for (int i = 0; i < SAMPLES; i++) begin
            if (model[i] < mn) mn = model[i];
            if (model[i] > mx) mx = model[i];
        end
        read = 1'b0;
        tick;
        read = 1'b1;
        tick;
        while (k < SAMPLES && cyc < 4 * SAMPLES) begin
            if (abort >= 0 && k == abort) return;
            chk("valid", sample_valid, 1);
            chk("ready_low", ready, 0);
            chk("raw", sample_raw, model[k]);
            chk("x", sample_x, 144 + k);
            chk("y", sample_y, 599 - (model[k] >> 3));
            chk("last", sample_last, k == SAMPLES - 1);
            chk("meas_quiet", meas_valid, 0);
            sample_ready = ($urandom_range(99) < pct);
            if (toggle) read = 1'($urandom_range(1));
            tick;
            if (sample_ready) k++;
            cyc++;
        end
        chk("all_samples", k, SAMPLES);
        chk("done_valid", sample_valid, 0);
        chk("done_ready", ready, 0);
        chk("meas_valid", meas_valid, 1);
        chk("vmin", vmin, mn);
        chk("vmax", vmax, mx);
        chk("vpp", vpp, mx - mn);
        read = 1'b1;
        tick;
        chk("rearm_ready", ready, 1);
        chk("meas_pulse", meas_valid, 0);
        chk("rearm_valid", sample_valid, 0);
        repeat (3) tick;
        chk("no_restart_valid", sample_valid, 0);
        chk("no_restart_ready", ready, 1);
    endtask

    initial begin
        load(0);
        #2 rst = 1'b0;
        tick;
        tick;
        chk("rst_ready", ready, 1);
        chk("rst_valid", sample_valid, 0);
        chk("rst_meas", meas_valid, 0);
        chk("rst_x", sample_x, 0);
        chk("rst_y", sample_y, 0);
        chk("rst_vmin", vmin, 0);
        chk("rst_vmax", vmax, 0);
        chk("rst_vpp", vpp, 0);
        rst = 1'b1;
        repeat (3) tick;
        chk("held_read_valid", sample_valid, 0);
        chk("held_read_ready", ready, 1);

        sample_ready = 1'b1;
        run_frame(100, 1'b0, -1);
        load(1);
        run_frame(50, 1'b1, -1);
        load(2);
        run_frame(100, 1'b0, -1);

        load(1);
        run_frame(100, 1'b0, 200);
        chk("pre_rst_x", sample_x, 344);
        rst = 1'b0;
        #1;
        chk("arst_valid", sample_valid, 0);
        chk("arst_ready", ready, 1);
        chk("arst_meas", meas_valid, 0);
        chk("arst_vmin", vmin, 0);
        chk("arst_vmax", vmax, 0);
        chk("arst_vpp", vpp, 0);
        tick;
        rst = 1'b1;
        repeat (5) begin
            tick;
            chk("post_rst_meas", meas_valid, 0);
            chk("post_rst_valid", sample_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
